// File: rtl/timer_unit_pkg.sv
// Shared definitions for the millisecond timer: FSM encoding and default clock.
// Latency: n/a (constants and a helper function only).
// Backpressure: n/a.
package timer_unit_pkg;

  // Input clock frequency used when the integrator does not override it.
  localparam int DEFAULT_CLK_FREQ_HZ = 27000000;

  // FSM encoding; IDLE must stay zero so a cleared register means idle.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } timer_state_e;

  // Clock cycles in one millisecond, never less than one so the prescaler
  // always has a legal wrap point.
  function automatic int cycles_per_ms(input int clk_hz);
    return ((clk_hz / 1000) < 1) ? 1 : (clk_hz / 1000);
  endfunction

endpackage

// File: rtl/timer_ms_tick.sv
// Millisecond prescaler: counts 0..CYCLES_PER_MS-1 while enabled, pulses ms_tick on wrap.
// Latency: ms_tick is combinational from the counter; first tick CYCLES_PER_MS cycles after clear.
// Backpressure: none; clear has priority over enable.
module timer_ms_tick
  import timer_unit_pkg::*;
#(
  parameter int CYCLES_PER_MS = cycles_per_ms(DEFAULT_CLK_FREQ_HZ)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic ms_tick
);

  localparam int CNT_W = (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_PER_MS - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // A clear in the same cycle suppresses the tick so a restart never
  // inherits a pending millisecond from the previous count.
  assign ms_tick = enable & ~clear & (cnt_q == CNT_LAST);

  // Next count: clear, wrap at the last cycle of the millisecond, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/timer_unit.sv
// Millisecond countdown timer: start rising edge loads time_ms, done/irq on expiry, busy while counting.
// Latency: done rises time_ms*CYCLES_PER_MS edges after the start edge (one edge for time_ms=0).
// Backpressure: none; start low aborts a run. Optional TIMER_AUTO_RELOAD_EN enables periodic reload.
module timer_unit
  import timer_unit_pkg::*;
#(
  parameter int CLK_FREQ_HZ = DEFAULT_CLK_FREQ_HZ
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] time_ms,
  input  logic        start,
  input  logic        interrupt_enable,
  output logic        done,
  output logic        irq,
  output logic        busy
);

  localparam int CYCLES_PER_MS = cycles_per_ms(CLK_FREQ_HZ);

  timer_state_e state_q;
  timer_state_e state_d;
  logic         start_q;
  logic [15:0]  remaining_q;
  logic [15:0]  remaining_d;
  logic         done_q;
  logic         done_d;
  logic         irq_q;
  logic         irq_d;

  logic         start_rise;
  logic         ms_tick;
  logic         presc_clear;
  logic         presc_en;

  assign start_rise  = start & ~start_q;
  assign presc_en    = (state_q == ST_RUN);
  // Restart or any non-running state keeps the prescaler at zero so each
  // count begins on a full millisecond.
  assign presc_clear = start_rise | (state_q != ST_RUN);

  timer_ms_tick #(
    .CYCLES_PER_MS(CYCLES_PER_MS)
  ) u_ms_tick (
    .clk    (clk),
    .rst    (rst),
    .clear  (presc_clear),
    .enable (presc_en),
    .ms_tick(ms_tick)
  );

  // Next-state logic: a start edge wins over everything, then abort, then ticks.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    done_d      = done_q;
    irq_d       = 1'b0;

    if (start_rise) begin
      // time_ms is captured only here; later changes do not affect the count.
      remaining_d = time_ms;
      done_d      = 1'b0;
      state_d     = (time_ms == 16'd0) ? ST_EXPIRED : ST_RUN;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end

        ST_RUN: begin
          if (!start) begin
            // Abort: drop the count silently.
            state_d = ST_IDLE;
          end else if (ms_tick) begin
            if (remaining_q > 16'd1) begin
              remaining_d = remaining_q - 16'd1;
            end else begin
              done_d = 1'b1;
              irq_d  = interrupt_enable;
`ifdef TIMER_AUTO_RELOAD_EN
              // Periodic mode: take a fresh period from the current time_ms.
              remaining_d = time_ms;
              state_d     = (time_ms == 16'd0) ? ST_EXPIRED : ST_RUN;
`else
              remaining_d = 16'd0;
              state_d     = ST_EXPIRED;
`endif
            end
          end
        end

        ST_EXPIRED: begin
          // A zero-length count lands here with done still clear; raise it
          // one edge after the start edge.
          if (!done_q) begin
            done_d = 1'b1;
            irq_d  = interrupt_enable;
          end
          if (!start) begin
            state_d = ST_IDLE;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers; reset overrides a simultaneous start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      start_q     <= 1'b0;
      remaining_q <= 16'd0;
      done_q      <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start;
      remaining_q <= remaining_d;
      done_q      <= done_d;
      irq_q       <= irq_d;
    end
  end

  assign done = done_q;
  assign irq  = irq_q;
  assign busy = (state_q == ST_RUN);

endmodule

// File: tb/tb_timer_unit.sv
// Self-checking bench for timer_unit at 4 kHz (4 cycles per ms).
// Latency: n/a.
// Backpressure: n/a.
module tb_timer_unit;

  localparam int CLK_HZ = 4000;
  localparam int CPM    = CLK_HZ / 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] time_ms = 16'd0;
  logic        interrupt_enable = 1'b0;
  logic        done;
  logic        irq;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a run is a deadline in absolute edge numbers.
  longint cyc = 0;
  longint m_deadline = 0;
  bit     m_sq = 1'b0;
  bit     m_run = 1'b0;
  bit     m_pend0 = 1'b0;
  bit     m_done = 1'b0;
  bit     m_irq = 1'b0;

  always #5 clk = ~clk;

  timer_unit #(.CLK_FREQ_HZ(CLK_HZ)) dut (
    .clk             (clk),
    .rst             (rst),
    .time_ms         (time_ms),
    .start           (start),
    .interrupt_enable(interrupt_enable),
    .done            (done),
    .irq             (irq),
    .busy            (busy)
  );

  task automatic model_edge();
    bit rise;
    cyc++;
    m_irq = 1'b0;
    if (rst) begin
      m_sq = 1'b0; m_run = 1'b0; m_pend0 = 1'b0; m_done = 1'b0;
    end else begin
      rise = start && !m_sq;
      if (rise) begin
        m_done     = 1'b0;
        m_run      = (time_ms != 16'd0);
        m_pend0    = (time_ms == 16'd0);
        m_deadline = cyc + longint'(time_ms) * CPM;
      end else if (m_run && !start) begin
        m_run = 1'b0;
      end else if (m_run && cyc == m_deadline) begin
        m_done = 1'b1;
        m_irq  = interrupt_enable;
`ifdef TIMER_AUTO_RELOAD_EN
        m_run      = (time_ms != 16'd0);
        m_deadline = cyc + longint'(time_ms) * CPM;
`else
        m_run = 1'b0;
`endif
      end else if (m_pend0) begin
        m_done  = 1'b1;
        m_irq   = interrupt_enable;
        m_pend0 = 1'b0;
      end
      m_sq = start;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    step(); step();
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_tests++; if (irq  !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want 0", irq); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_one_shot();
    int first_done = -1, busy_cnt = 0, irq_cnt = 0, irq_at = -1;
    start = 1'b0; time_ms = 16'd3; interrupt_enable = 1'b1; step();
    start = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step();
      if (k == 2) time_ms = 16'd9;
      n_tests++; if (done !== m_done) begin n_fail++; $display("FAIL one_shot_done k=%0d got %b want %b", k, done, m_done); end
      n_tests++; if (irq  !== m_irq)  begin n_fail++; $display("FAIL one_shot_irq k=%0d got %b want %b", k, irq, m_irq); end
      n_tests++; if (busy !== m_run)  begin n_fail++; $display("FAIL one_shot_busy k=%0d got %b want %b", k, busy, m_run); end
      if (done && first_done < 0) first_done = k;
      if (busy) busy_cnt++;
      if (irq) begin irq_cnt++; irq_at = k; end
    end
    n_tests++; if (first_done != 12) begin n_fail++; $display("FAIL one_shot_latency got %0d want 12", first_done); end
    n_tests++; if (busy_cnt != 12)   begin n_fail++; $display("FAIL one_shot_busy_len got %0d want 12", busy_cnt); end
    n_tests++; if (irq_cnt != 1)     begin n_fail++; $display("FAIL one_shot_irq_cnt got %0d want 1", irq_cnt); end
    n_tests++; if (irq_at != 12)     begin n_fail++; $display("FAIL one_shot_irq_at got %0d want 12", irq_at); end
  endtask

  task automatic test_zero_time();
    int first_done = -1, busy_cnt = 0, irq_cnt = 0;
    start = 1'b0; time_ms = 16'd0; interrupt_enable = 1'b1; step();
    start = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      n_tests++; if (done !== m_done) begin n_fail++; $display("FAIL zero_done k=%0d got %b want %b", k, done, m_done); end
      n_tests++; if (irq  !== m_irq)  begin n_fail++; $display("FAIL zero_irq k=%0d got %b want %b", k, irq, m_irq); end
      n_tests++; if (busy !== m_run)  begin n_fail++; $display("FAIL zero_busy k=%0d got %b want %b", k, busy, m_run); end
      if (done && first_done < 0) first_done = k;
      if (busy) busy_cnt++;
      if (irq) irq_cnt++;
    end
    n_tests++; if (first_done != 1) begin n_fail++; $display("FAIL zero_latency got %0d want 1", first_done); end
    n_tests++; if (busy_cnt != 0)   begin n_fail++; $display("FAIL zero_busy_cnt got %0d want 0", busy_cnt); end
    n_tests++; if (irq_cnt != 1)    begin n_fail++; $display("FAIL zero_irq_cnt got %0d want 1", irq_cnt); end
  endtask

  task automatic test_abort();
    int done_cnt = 0, irq_cnt = 0, first_done = -1;
    start = 1'b0; time_ms = 16'd5; interrupt_enable = 1'b1; step();
    start = 1'b1;
    for (int k = 0; k < 14; k++) begin
      step();
      if (k == 7) start = 1'b0;
      n_tests++; if (done !== m_done) begin n_fail++; $display("FAIL abort_done k=%0d got %b want %b", k, done, m_done); end
      n_tests++; if (irq  !== m_irq)  begin n_fail++; $display("FAIL abort_irq k=%0d got %b want %b", k, irq, m_irq); end
      n_tests++; if (busy !== m_run)  begin n_fail++; $display("FAIL abort_busy k=%0d got %b want %b", k, busy, m_run); end
      if (done) done_cnt++;
      if (irq) irq_cnt++;
    end
    n_tests++; if (done_cnt != 0) begin n_fail++; $display("FAIL abort_done_cnt got %0d want 0", done_cnt); end
    n_tests++; if (irq_cnt != 0)  begin n_fail++; $display("FAIL abort_irq_cnt got %0d want 0", irq_cnt); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle_busy got %b want 0", busy); end
    time_ms = 16'd1; start = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      n_tests++; if (done !== m_done) begin n_fail++; $display("FAIL rerun_done k=%0d got %b want %b", k, done, m_done); end
      if (done && first_done < 0) first_done = k;
    end
    n_tests++; if (first_done != 4) begin n_fail++; $display("FAIL rerun_latency got %0d want 4", first_done); end
  endtask

  task automatic test_no_irq_hold();
    int first_done = -1, irq_cnt = 0;
    start = 1'b0; time_ms = 16'd2; interrupt_enable = 1'b0; step();
    start = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (k == 10) start = 1'b0;
      n_tests++; if (done !== m_done) begin n_fail++; $display("FAIL noirq_done k=%0d got %b want %b", k, done, m_done); end
      n_tests++; if (irq  !== m_irq)  begin n_fail++; $display("FAIL noirq_irq k=%0d got %b want %b", k, irq, m_irq); end
      n_tests++; if (busy !== m_run)  begin n_fail++; $display("FAIL noirq_busy k=%0d got %b want %b", k, busy, m_run); end
      if (done && first_done < 0) first_done = k;
      if (irq) irq_cnt++;
    end
    n_tests++; if (first_done != 8) begin n_fail++; $display("FAIL noirq_latency got %0d want 8", first_done); end
    n_tests++; if (irq_cnt != 0)    begin n_fail++; $display("FAIL noirq_irq_cnt got %0d want 0", irq_cnt); end
    n_tests++; if (done !== 1'b1)   begin n_fail++; $display("FAIL noirq_hold got %b want 1", done); end
    start = 1'b1;
    step();
    n_tests++; if (done !== 1'b0)   begin n_fail++; $display("FAIL noirq_clear_on_rise got %b want 0", done); end
  endtask

  task automatic test_reset_mid_run();
    int first_done = -1, irq_cnt = 0;
    start = 1'b0; time_ms = 16'd3; interrupt_enable = 1'b1; step();
    start = 1'b1;
    for (int k = 0; k < 5; k++) step();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      n_tests++; if ({done, irq, busy} !== 3'b000) begin n_fail++; $display("FAIL rst_outputs k=%0d got %b want 000", k, {done, irq, busy}); end
    end
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      step();
      n_tests++; if (done !== m_done) begin n_fail++; $display("FAIL rstrun_done k=%0d got %b want %b", k, done, m_done); end
      n_tests++; if (busy !== m_run)  begin n_fail++; $display("FAIL rstrun_busy k=%0d got %b want %b", k, busy, m_run); end
      if (done && first_done < 0) first_done = k;
      if (irq) irq_cnt++;
    end
    n_tests++; if (first_done != 12) begin n_fail++; $display("FAIL rstrun_latency got %0d want 12", first_done); end
    n_tests++; if (irq_cnt != 1)     begin n_fail++; $display("FAIL rstrun_irq_cnt got %0d want 1", irq_cnt); end
  endtask

`ifdef TIMER_AUTO_RELOAD_EN
  task automatic test_auto_reload();
    start = 1'b0; time_ms = 16'd1; interrupt_enable = 1'b1; step();
    start = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      n_tests++; if (irq !== ((k >= 4) && (k % 4 == 0))) begin n_fail++; $display("FAIL reload_irq k=%0d got %b", k, irq); end
      n_tests++; if (done !== (k >= 4)) begin n_fail++; $display("FAIL reload_done k=%0d got %b", k, done); end
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reload_busy k=%0d got %b want 1", k, busy); end
    end
  endtask
`endif

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 11) == 0) start = ~start;
      if ($urandom_range(0, 3) == 0) time_ms = 16'($urandom_range(0, 6));
      if ($urandom_range(0, 7) == 0) interrupt_enable = 1'($urandom_range(0, 1));
      step();
      n_tests++; if (done !== m_done) begin n_fail++; $display("FAIL rand_done k=%0d got %b want %b", k, done, m_done); end
      n_tests++; if (irq  !== m_irq)  begin n_fail++; $display("FAIL rand_irq k=%0d got %b want %b", k, irq, m_irq); end
      n_tests++; if (busy !== m_run)  begin n_fail++; $display("FAIL rand_busy k=%0d got %b want %b", k, busy, m_run); end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_zero_time();
    test_abort();
    test_no_irq_hold();
    test_reset_mid_run();
`ifdef TIMER_AUTO_RELOAD_EN
    test_auto_reload();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
